// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end time-sharing one 32-bit ALU
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_out,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_cout,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state;
    logic        ptr, grant, op_id, sub, c31;
    logic [31:0] op_a, op_b, b_eff, alu_out;
    logic [3:0]  op_ctrl;
    logic [32:0] sum;
    logic        alu_ovf, alu_cout, alu_err;
    always_comb begin
        grant     = (&req_valid) ? ptr : req_valid[1];
        req_ready = (state == IDLE && !rst) ? req_valid & (grant ? 2'b10 : 2'b01) : 2'b00;
    end
    // SUB and SLT share the adder with inverted b and carry-in of 1
    always_comb begin
        sub      = op_ctrl == 4'b0110 || op_ctrl == 4'b0111;
        b_eff    = sub ? ~op_b : op_b;
        sum      = {1'b0, op_a} + {1'b0, b_eff} + {32'b0, sub};
        c31      = op_a[31] ^ b_eff[31] ^ sum[31];
        alu_out  = '0;
        alu_ovf  = 1'b0;
        alu_cout = 1'b0;
        alu_err  = 1'b0;
        case (op_ctrl)
            4'b0000: alu_out = op_a & op_b;
            4'b0001: alu_out = op_a | op_b;
            4'b0010, 4'b0110: begin
                alu_out  = sum[31:0];
                alu_cout = sum[32];
                alu_ovf  = c31 ^ sum[32];
            end
            4'b0111: alu_out = {31'b0, sum[31]};
            4'b1100: alu_out = ~(op_a | op_b);
            default: alu_err = 1'b1;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            op_id        <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            op_ctrl      <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_out      <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_cout     <= 1'b0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            ops_done     <= '0;
        end else begin
            case (state)
                IDLE: if (|req_ready) begin
                    op_a    <= grant ? req1_a : req0_a;
                    op_b    <= grant ? req1_b : req0_b;
                    op_ctrl <= grant ? req1_ctrl : req0_ctrl;
                    op_id   <= grant;
                    busy    <= 1'b1;
                    state   <= EXEC;
                end
                EXEC: begin
                    rsp_out      <= alu_out;
                    rsp_zero     <= alu_out == 32'b0;
                    rsp_overflow <= alu_ovf;
                    rsp_cout     <= alu_cout;
                    rsp_err      <= alu_err;
                    rsp_id       <= op_id;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    ptr       <= ~rsp_id;
                    ops_done  <= ops_done + CNT_W'(1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_cout, rsp_err, busy;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_out;
    logic [15:0] ops_done;
    int          checks = 0;
    int          errors = 0;

    alu_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_cout(rsp_cout),
        .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Issues one request from IDLE at posedge+1 and returns at posedge+1 of the RESP cycle
    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                          output logic [1:0] rdy, output logic [1:0] exec_rdy, output logic exec_valid, output logic exec_busy);
        req_valid = id ? 2'b10 : 2'b01;
        if (id) begin req1_a = a; req1_b = b; req1_ctrl = ctrl; end
        else begin req0_a = a; req0_b = b; req0_ctrl = ctrl; end
        #1 rdy = req_ready;
        @(posedge clk); #1;
        exec_rdy = req_ready; exec_valid = rsp_valid; exec_busy = busy;
        req_valid = 2'b00;
        req0_a = ~req0_a; req0_b = ~req0_b; req0_ctrl = req0_ctrl ^ 4'b0101;
        req1_a = ~req1_a; req1_b = ~req1_b; req1_ctrl = req1_ctrl ^ 4'b0101;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if ({rsp_id, rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {rsp_id, rsp_zero, rsp_overflow, rsp_cout, rsp_err}); end
        checks++; if (rsp_out !== 32'h0) begin errors++; $display("FAIL reset_rsp_out: got %h expected 00000000", rsp_out); end
        checks++; if (ops_done !== 16'h0) begin errors++; $display("FAIL reset_ops_done: got %0d expected 0", ops_done); end
        req_valid = 2'b00;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        logic [1:0] rdy, erdy;
        logic ev, eb;
        rsp_ready = 1'b1;
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, rdy, erdy, ev, eb);
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL add_grant: got %b expected 01", rdy); end
        checks++; if ({erdy, ev, eb} !== 4'b0001) begin errors++; $display("FAIL add_exec_state: got %b expected 0001", {erdy, ev, eb}); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL add_rsp_id: got %b expected 0", rsp_id); end
        checks++; if (rsp_out !== 32'h8000_0000) begin errors++; $display("FAIL add_out: got %h expected 80000000", rsp_out); end
        checks++; if ({rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== 4'b0100) begin errors++; $display("FAIL add_flags: got %b expected 0100", {rsp_zero, rsp_overflow, rsp_cout, rsp_err}); end
        @(posedge clk); #1;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_done: got %b expected 00", {rsp_valid, busy}); end
        checks++; if (ops_done !== 16'd1) begin errors++; $display("FAIL add_ops_done: got %0d expected 1", ops_done); end
    endtask

    task automatic test_sub_slt;
        logic [1:0] rdy, erdy;
        logic ev, eb;
        run_op(1'b1, 32'd5, 32'd5, 4'b0110, rdy, erdy, ev, eb);
        checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL sub_grant: got %b expected 10", rdy); end
        checks++; if ({rsp_valid, rsp_id} !== 2'b11) begin errors++; $display("FAIL sub_valid_id: got %b expected 11", {rsp_valid, rsp_id}); end
        checks++; if (rsp_out !== 32'h0) begin errors++; $display("FAIL sub_out: got %h expected 00000000", rsp_out); end
        checks++; if ({rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== 4'b1010) begin errors++; $display("FAIL sub_flags: got %b expected 1010", {rsp_zero, rsp_overflow, rsp_cout, rsp_err}); end
        @(posedge clk); #1;
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0111, rdy, erdy, ev, eb);
        checks++; if (rsp_out !== 32'h1) begin errors++; $display("FAIL slt_out: got %h expected 00000001", rsp_out); end
        checks++; if ({rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== 4'b0000) begin errors++; $display("FAIL slt_flags: got %b expected 0000", {rsp_zero, rsp_overflow, rsp_cout, rsp_err}); end
        @(posedge clk); #1;
        checks++; if (ops_done !== 16'd3) begin errors++; $display("FAIL slt_ops_done: got %0d expected 3", ops_done); end
    endtask

    task automatic test_err;
        logic [1:0] rdy, erdy;
        logic ev, eb;
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, rdy, erdy, ev, eb);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL err_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_out !== 32'h0) begin errors++; $display("FAIL err_out: got %h expected 00000000", rsp_out); end
        checks++; if ({rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== 4'b1001) begin errors++; $display("FAIL err_flags: got %b expected 1001", {rsp_zero, rsp_overflow, rsp_cout, rsp_err}); end
        @(posedge clk); #1;
        checks++; if (ops_done !== 16'd4) begin errors++; $display("FAIL err_ops_done: got %0d expected 4", ops_done); end
    endtask

    task automatic test_stall;
        logic [1:0] rdy, erdy;
        logic ev, eb;
        rsp_ready = 1'b0;
        run_op(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 4'b0000, rdy, erdy, ev, eb);
        checks++; if (rsp_out !== 32'h0204_0608) begin errors++; $display("FAIL stall_and_out: got %h expected 02040608", rsp_out); end
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if ({rsp_valid, req_ready} !== 3'b100) begin errors++; $display("FAIL stall_hold_%0d: got valid/ready %b expected 100", i, {rsp_valid, req_ready}); end
            checks++; if (rsp_out !== 32'h0204_0608) begin errors++; $display("FAIL stall_out_%0d: got %h expected 02040608", i, rsp_out); end
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL stall_release: got %b expected 00", {rsp_valid, busy}); end
        checks++; if (ops_done !== 16'd5) begin errors++; $display("FAIL stall_ops_done: got %0d expected 5", ops_done); end
    endtask

    task automatic test_reset_exec;
        logic seen;
        rsp_ready = 1'b1;
        req_valid = 2'b10; req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 4'b0010;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rexec_busy: got %b expected 1", busy); end
        #2 rst = 1'b1; req_valid = 2'b11;
        #1;
        checks++; if ({busy, rsp_valid, req_ready} !== 4'b0000) begin errors++; $display("FAIL rexec_async: got %b expected 0000", {busy, rsp_valid, req_ready}); end
        checks++; if (rsp_out !== 32'h0) begin errors++; $display("FAIL rexec_out: got %h expected 00000000", rsp_out); end
        checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL rexec_ops_done: got %0d expected 0", ops_done); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rexec_ready_in_rst: got %b expected 00", req_ready); end
        rst = 1'b0; req_valid = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rexec_ghost_rsp: got %b expected 0", seen); end
    endtask

    task automatic test_back_to_back;
        logic exp;
        rst = 1'b1;
        #2 rst = 1'b0;
        req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 4'b0010;
        req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 4'b0001;
        req_valid = 2'b11; rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp = i[0];
            checks++; if (req_ready !== (exp ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", i, req_ready, exp ? 2'b10 : 2'b01); end
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++; if ({rsp_valid, rsp_id} !== {1'b1, exp}) begin errors++; $display("FAIL rr_rsp_%0d: got %b expected %b", i, {rsp_valid, rsp_id}, {1'b1, exp}); end
            checks++; if (rsp_out !== (exp ? 32'hFF : 32'h3)) begin errors++; $display("FAIL rr_out_%0d: got %h expected %h", i, rsp_out, exp ? 32'hFF : 32'h3); end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        checks++; if (ops_done !== 16'd4) begin errors++; $display("FAIL rr_ops_done: got %0d expected 4", ops_done); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_add;
        test_sub_slt;
        test_err;
        test_stall;
        test_reset_exec;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
